// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Stall/flush sequencer for the 5-stage core, paired with forwarding_unit.
//   Covers the hazards forwarding cannot resolve (load-use, ID-stage compares
//   on a not-yet-ready rd). It holds the pipeline for the multi-cycle MDU and
//   for data-memory wait states, and flushes on taken branches (ID) and on
//   traps (MEM).
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
//   stall_cycles counter. Without it, stall_cycles is tied to 0 and no
//   counter flops exist.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   forwarding_type_id    forwarding class of the instruction in ID
//   rs1_id, rs2_id        ID source registers
//   rd_ex, rd_mem         EX / MEM destination registers
//   reg_we_ex             EX instruction writes rd
//   mem_rd_ex, mem_rd_mem EX / MEM instruction is a load
//   mdu_start_ex          MUL/DIV in EX, MDU starts this cycle
//   mdu_done              MDU result valid (1-cycle pulse)
//   mem_busy              data memory not ready for the MEM access
//   branch_taken_id       taken branch/jump resolved in ID
//   trap_mem              trap committed in MEM
//   stall_if/id/ex/mem    hold PC/IF-ID, IF-ID, ID-EX, EX-MEM
//   bubble_ex/mem/wb      insert NOP into ID-EX, EX-MEM, MEM-WB
//   flush_if              squash IF-ID contents
//   mdu_abort             cancel the MDU operation (1-cycle pulse)
//   stall_cycles          number of cycles with stall_if=1
// -----------------------------------------------------------------------------
package hazard_pkg;
   typedef enum logic [1:0] {
      FWD_NONE    = 2'd0,
      FWD_TYPE1   = 2'd1,
      FWD_TYPE1_3 = 2'd2,
      FWD_TYPE2   = 2'd3
   } forwarding_type_t;
endpackage

module hazard_controller
   import hazard_pkg::*;
#(
   parameter int STALL_CNT_WIDTH = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  forwarding_type_t           forwarding_type_id,
   input  logic [4:0]                 rs1_id,
   input  logic [4:0]                 rs2_id,
   input  logic [4:0]                 rd_ex,
   input  logic [4:0]                 rd_mem,
   input  logic                       reg_we_ex,
   input  logic                       mem_rd_ex,
   input  logic                       mem_rd_mem,
   input  logic                       mdu_start_ex,
   input  logic                       mdu_done,
   input  logic                       mem_busy,
   input  logic                       branch_taken_id,
   input  logic                       trap_mem,
   output logic                       stall_if,
   output logic                       stall_id,
   output logic                       stall_ex,
   output logic                       stall_mem,
   output logic                       bubble_ex,
   output logic                       bubble_mem,
   output logic                       bubble_wb,
   output logic                       flush_if,
   output logic                       mdu_abort,
   output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic hit_ex;
   logic hit_mem;
   logic load_use;

   // Hazards that forwarding cannot cover; x0 never creates a dependency.
   always_comb begin
      hit_ex   = (rd_ex  != 5'd0) && ((rd_ex  == rs1_id) || (rd_ex  == rs2_id));
      hit_mem  = (rd_mem != 5'd0) && ((rd_mem == rs1_id) || (rd_mem == rs2_id));
      load_use = 1'b0;
      case (forwarding_type_id)
         FWD_TYPE1, FWD_TYPE1_3: load_use = mem_rd_ex && hit_ex;
         // ID-stage compare: needs operands before EX/MEM can forward them,
         // so a load in EX costs two cycles (EX then MEM).
         FWD_TYPE2: load_use = (reg_we_ex && (rd_ex != 5'd0) && (rd_ex == rs2_id))
                            || (mem_rd_ex && hit_ex)
                            || (mem_rd_mem && hit_mem);
         default:   load_use = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      stall_mem  = 1'b0;
      bubble_ex  = 1'b0;
      bubble_mem = 1'b0;
      bubble_wb  = 1'b0;
      flush_if   = 1'b0;
      mdu_abort  = 1'b0;

      case (state_q)
         MDU_WAIT: begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
            if (mdu_done) begin
               state_d = RUN;
            end
         end
         default: begin
            // RUN and MEM_WAIT share this path: a memory wait is held exactly
            // while mem_busy is high, and once it drops the cycle is a normal
            // RUN cycle (load-use and MDU entry evaluated again).
            if (mem_busy) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               stall_ex  = 1'b1;
               stall_mem = 1'b1;
               bubble_wb = 1'b1;
               state_d   = MEM_WAIT;
            end else begin
               state_d = RUN;
               if (load_use) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
               // A same-cycle done means the result is already available.
               if (mdu_start_ex && !mdu_done) begin
                  state_d = MDU_WAIT;
               end
            end
         end
      endcase

      // Branch operands are not valid while ID is held.
      flush_if = branch_taken_id && !stall_id;

      if (trap_mem) begin
         stall_if   = 1'b0;
         stall_id   = 1'b0;
         stall_ex   = 1'b0;
         stall_mem  = 1'b0;
         bubble_wb  = 1'b0;
         flush_if   = 1'b1;
         bubble_ex  = 1'b1;
         bubble_mem = 1'b1;
         // An op that completes this cycle has nothing left to cancel.
         mdu_abort  = ((state_q == MDU_WAIT) || mdu_start_ex) && !mdu_done;
         state_d    = RUN;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [STALL_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_if && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + STALL_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
